// File: rtl/fpu_addsub_arbiter_pkg.sv
// Shared types and constants for the bf16 add/sub arbiter and its datapath.
package fpu_addsub_arbiter_pkg;

  typedef enum logic [2:0] {
    FP_ALU_ADD = 3'd0,
    FP_ALU_SUB = 3'd1,
    FP_ALU_MUL = 3'd2,
    FP_ALU_MIN = 3'd3,
    FP_ALU_MAX = 3'd4,
    FP_ALU_CMP = 3'd5
  } fp_alu_op_e;

  localparam logic [15:0] FP_BF16_QNAN = 16'h7FC0;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } fpu_arb_state_e;

  function automatic logic fp_op_is_addsub(input fp_alu_op_e op);
    return (op == FP_ALU_ADD) || (op == FP_ALU_SUB);
  endfunction

endpackage

// File: rtl/Add_Sub.sv
// Combinational bf16 adder/subtractor, round-to-nearest-even. Subnormal
// inputs and results are flushed to signed zero.
module Add_Sub
  import fpu_addsub_arbiter_pkg::*;
(
  input  fp_alu_op_e  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] result_o
);

  logic              sign_a, sign_b, sign_l, sign_s, swap;
  logic              nan_a, nan_b, inf_a, inf_b;
  logic [7:0]        exp_a, exp_b, exp_l, exp_s, exp_diff;
  logic [7:0]        man_a, man_b, man_l, man_s;
  logic [4:0]        shamt, lead, norm_sh;
  logic [39:0]       align;
  logic [19:0]       op_l, op_s, sum, norm;
  logic              rnd_up;
  logic [8:0]        man_rnd;
  logic signed [9:0] exp_r;

  assign sign_a = a_i[15];
  assign sign_b = b_i[15] ^ (op_i == FP_ALU_SUB);
  assign exp_a  = a_i[14:7];
  assign exp_b  = b_i[14:7];
  assign man_a  = (exp_a == 8'd0) ? 8'd0 : {1'b1, a_i[6:0]};
  assign man_b  = (exp_b == 8'd0) ? 8'd0 : {1'b1, b_i[6:0]};
  assign nan_a  = (exp_a == 8'hFF) && (|a_i[6:0]);
  assign nan_b  = (exp_b == 8'hFF) && (|b_i[6:0]);
  assign inf_a  = (exp_a == 8'hFF) && !(|a_i[6:0]);
  assign inf_b  = (exp_b == 8'hFF) && !(|b_i[6:0]);

  assign swap   = b_i[14:0] > a_i[14:0];
  assign sign_l = swap ? sign_b : sign_a;
  assign sign_s = swap ? sign_a : sign_b;
  assign exp_l  = swap ? exp_b : exp_a;
  assign exp_s  = swap ? exp_a : exp_b;
  assign man_l  = swap ? man_b : man_a;
  assign man_s  = swap ? man_a : man_b;

  // Sticky sits in its own LSB below the aligned field so that a borrow in
  // subtraction can never move the value across a rounding boundary.
  assign exp_diff = exp_l - exp_s;
  assign shamt    = (exp_diff > 8'd22) ? 5'd22 : exp_diff[4:0];
  assign align    = {man_s, 32'd0} >> shamt;
  assign op_l     = {1'b0, man_l, 11'd0};
  assign op_s     = {1'b0, align[39:22], |align[21:0]};
  assign sum      = (sign_l == sign_s) ? op_l + op_s : op_l - op_s;

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (sum[i]) lead = 5'(i);
    end
  end

  assign norm_sh = 5'd19 - lead;
  assign norm    = sum << norm_sh;
  assign rnd_up  = norm[11] & ((|norm[10:0]) | norm[12]);
  assign man_rnd = {1'b0, norm[19:12]} + {8'd0, rnd_up};
  assign exp_r   = $signed({2'b00, exp_l}) + 10'sd1 - $signed({5'd0, norm_sh})
                 + $signed({9'd0, man_rnd[8]});

  always_comb begin
    result_o = {sign_l, exp_r[7:0], man_rnd[6:0]};
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      result_o = FP_BF16_QNAN;
    end else if (inf_a) begin
      result_o = {sign_a, 8'hFF, 7'd0};
    end else if (inf_b) begin
      result_o = {sign_b, 8'hFF, 7'd0};
    end else if (sum == 20'd0) begin
      result_o = {sign_l & sign_s, 15'd0};
    end else if (exp_r >= 10'sd255) begin
      result_o = {sign_l, 8'hFF, 7'd0};
    end else if (exp_r <= 10'sd0) begin
      result_o = {sign_l, 15'd0};
    end
  end

endmodule

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin grant with its own priority pointer; the pointer moves
// to the other requester whenever advance_i reports an accepted grant.
module fpu_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;
  logic gnt_idx;

  // ptr_q = 0 favours requester 0 when both are asking
  always_comb begin
    gnt_idx = (valid_i == 2'b11) ? ptr_q : valid_i[1];
    grant_o = 2'b00;
    if (valid_i != 2'b00) begin
      grant_o[gnt_idx] = 1'b1;
    end
    ptr_d = advance_i ? ~gnt_idx : ptr_q;
  end

  assign gnt_idx_o = gnt_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin sharing of one bf16 Add_Sub datapath between two requesters,
// one operation in flight, result held until the consumer takes it.
module fpu_addsub_arbiter
  import fpu_addsub_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  fp_alu_op_e            req_op_i [2],
  input  logic [1:0][15:0]      req_a_i,
  input  logic [1:0][15:0]      req_b_i,
  input  logic [1:0][TAG_W-1:0] req_tag_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_id_o,
  output logic [15:0]           rsp_result_o,
  output logic [TAG_W-1:0]      rsp_tag_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  fpu_arb_state_e   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  fp_alu_op_e       op_q, op_d;
  logic [15:0]      a_q, a_d, b_q, b_d, res_q, res_d, dp_result;
  logic [TAG_W-1:0] tag_q, tag_d, rsp_tag_q, rsp_tag_d;
  logic             id_q, id_d, rsp_id_q, rsp_id_d, err_q, err_d;
  logic [1:0]       grant;
  logic             gnt_idx, accept_en, handshake;

  assign accept_en   = (state_q == ARB_IDLE) && !flush_i && rst_ni;
  assign req_ready_o = accept_en ? grant : 2'b00;
  assign handshake   = accept_en && (req_valid_i != 2'b00);

  fpu_rr_arb2 u_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (req_valid_i),
    .advance_i (handshake),
    .grant_o   (grant),
    .gnt_idx_o (gnt_idx)
  );

  // Operand registers stay frozen through EXEC: the datapath is timed as a
  // LATENCY-cycle multicycle path from these flops to res_q.
  Add_Sub u_add_sub (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (dp_result)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    id_d      = id_q;
    res_d     = res_q;
    rsp_tag_d = rsp_tag_q;
    rsp_id_d  = rsp_id_q;
    err_d     = err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (handshake) begin
          op_d    = req_op_i[gnt_idx];
          a_d     = req_a_i[gnt_idx];
          b_d     = req_b_i[gnt_idx];
          tag_d   = req_tag_i[gnt_idx];
          id_d    = gnt_idx;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d     = fp_op_is_addsub(op_q) ? dp_result : FP_BF16_QNAN;
          err_d     = !fp_op_is_addsub(op_q);
          rsp_tag_d = tag_q;
          rsp_id_d  = id_q;
          state_d   = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ARB_RESP: begin
        if (rsp_ready_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (flush_i) state_d = ARB_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      op_q      <= FP_ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      id_q      <= 1'b0;
      res_q     <= '0;
      rsp_tag_q <= '0;
      rsp_id_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      id_q      <= id_d;
      res_q     <= res_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_id_q  <= rsp_id_d;
      err_q     <= err_d;
    end
  end

  assign rsp_valid_o  = (state_q == ARB_RESP);
  assign busy_o       = (state_q != ARB_IDLE);
  assign rsp_result_o = res_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Self-checking bench for fpu_addsub_arbiter: directed vector table, corner
// sequences (backpressure, flush, async reset) and randomized traffic.
module tb_fpu_addsub_arbiter;
  import fpu_addsub_arbiter_pkg::*;

  localparam int LATENCY = 2;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             rstN;
  logic             flush;
  logic [1:0]       reqValid, reqReady;
  fp_alu_op_e       reqOp [2];
  logic [1:0][15:0] reqA, reqB;
  logic [1:0][3:0]  reqTag;
  logic             rspValid, rspReady, rspId, rspErr, busy;
  logic [15:0]      rspResult;
  logic [3:0]       rspTag;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic        modelPtr;
  logic [15:0] expRes [2];
  logic        expErr [2];

  typedef struct {
    logic        port;
    fp_alu_op_e  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  fpu_addsub_arbiter #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .flush_i      (flush),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_op_i     (reqOp),
    .req_a_i      (reqA),
    .req_b_i      (reqB),
    .req_tag_i    (reqTag),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_id_o     (rspId),
    .rsp_result_o (rspResult),
    .rsp_tag_o    (rspTag),
    .rsp_err_o    (rspErr),
    .busy_o       (busy)
  );

  function automatic real bf16ToReal(input logic [15:0] x);
    real mag;
    if (x[14:7] == 8'd0) return 0.0;
    mag = (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** (real'(int'(x[14:7])) - 127.0));
    return x[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] realToBf16(input real r);
    logic [63:0] bits;
    int          e;
    logic [8:0]  m;
    logic        up;
    if (r == 0.0) return 16'h0000;
    bits = $realtobits(r);
    e    = int'(bits[62:52]) - 1023 + 127;
    up   = bits[44] & ((|bits[43:0]) | bits[45]);
    m    = {2'b01, bits[51:45]} + {8'd0, up};
    if (m[8]) e = e + 1;
    return {bits[63], 8'(e), m[6:0]};
  endfunction

  // Reference: exact sum in double precision, then one RNE rounding to bf16
  function automatic logic [16:0] refModel(input fp_alu_op_e op, input logic [15:0] a,
                                           input logic [15:0] b);
    real r;
    if (op != FP_ALU_ADD && op != FP_ALU_SUB) return {1'b1, FP_BF16_QNAN};
    r = (op == FP_ALU_ADD) ? bf16ToReal(a) + bf16ToReal(b) : bf16ToReal(a) - bf16ToReal(b);
    return {1'b0, realToBf16(r)};
  endfunction

  function automatic logic [15:0] randBf16();
    return {1'($urandom), 8'($urandom_range(120, 135)), 7'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One complete transaction: grant check, latency, response fields,
  // optional backpressure window, then the response handshake.
  task automatic applyStimulus(input logic [1:0] valid, input int holdCycles,
                               input logic keepValid);
    int         g;
    int         cycles;
    logic [1:0] expGnt;
    reqValid = valid;
    g        = (valid == 2'b11) ? (modelPtr ? 1 : 0) : (valid[1] ? 1 : 0);
    expGnt   = (g == 0) ? 2'b01 : 2'b10;
    #1;
    checkOutput("req_ready_grant", 32'(reqReady), 32'(expGnt));
    tick();
    modelPtr = (g == 0);
    if (!keepValid) reqValid = 2'b00;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("req_ready_in_exec", 32'(reqReady), 32'd0);
    cycles = 0;
    while (!rspValid && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 32'(LATENCY));
    checkOutput("rsp_result", 32'(rspResult), 32'(expRes[g]));
    checkOutput("rsp_err", 32'(rspErr), 32'(expErr[g]));
    checkOutput("rsp_id", 32'(rspId), 32'(g));
    checkOutput("rsp_tag", 32'(rspTag), 32'(reqTag[g]));
    for (int h = 0; h < holdCycles; h++) begin
      tick();
      checkOutput("hold_valid", 32'(rspValid), 32'd1);
      checkOutput("hold_result", 32'(rspResult), 32'(expRes[g]));
      checkOutput("hold_tag", 32'(rspTag), 32'(reqTag[g]));
      checkOutput("hold_id", 32'(rspId), 32'(g));
      checkOutput("hold_req_ready", 32'(reqReady), 32'd0);
    end
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("rsp_valid_cleared", 32'(rspValid), 32'd0);
    checkOutput("idle_after_rsp", 32'(busy), 32'd0);
  endtask

  task automatic setPort(input int p, input fp_alu_op_e op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] tag);
    reqOp[p]  = op;
    reqA[p]   = a;
    reqB[p]   = b;
    reqTag[p] = tag;
    {expErr[p], expRes[p]} = refModel(op, a, b);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawValid;
    rstN     = 1'b0;
    flush    = 1'b0;
    reqValid = 2'b00;
    rspReady = 1'b0;
    reqOp[0] = FP_ALU_ADD;
    reqOp[1] = FP_ALU_ADD;
    reqA     = '0;
    reqB     = '0;
    reqTag   = '0;
    modelPtr = 1'b0;

    vecs[0] = '{1'b0, FP_ALU_ADD, 16'h3F80, 16'h4000, 4'h5, 16'h4040, 1'b0};
    vecs[1] = '{1'b1, FP_ALU_MUL, 16'h3F80, 16'h4000, 4'h3, 16'h7FC0, 1'b1};
    vecs[2] = '{1'b0, FP_ALU_SUB, 16'h4040, 16'h3F80, 4'h1, 16'h4000, 1'b0};
    vecs[3] = '{1'b1, FP_ALU_ADD, 16'h3F80, 16'hBF80, 4'h2, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, FP_ALU_ADD, 16'h3FC0, 16'h3FC0, 4'h7, 16'h4040, 1'b0};
    vecs[5] = '{1'b1, FP_ALU_ADD, 16'h3F80, 16'h3B80, 4'h9, 16'h3F80, 1'b0};
    vecs[6] = '{1'b0, FP_ALU_ADD, 16'h3F81, 16'h3B80, 4'hA, 16'h3F82, 1'b0};
    vecs[7] = '{1'b1, FP_ALU_ADD, 16'h7F80, 16'h3F80, 4'hB, 16'h7F80, 1'b0};
    vecs[8] = '{1'b0, FP_ALU_SUB, 16'h7F80, 16'h7F80, 4'hC, 16'h7FC0, 1'b0};
    vecs[9] = '{1'b1, FP_ALU_CMP, 16'h0000, 16'h0000, 4'hF, 16'h7FC0, 1'b1};

    // Reset values
    #12;
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_req_ready", 32'(reqReady), 32'd0);
    checkOutput("reset_result", 32'(rspResult), 32'd0);
    checkOutput("reset_tag_id_err", 32'({rspTag, rspId, rspErr}), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    tick();

    // Both requesters held valid: grants alternate 0,1,0,1
    setPort(0, FP_ALU_ADD, 16'h3F80, 16'h3F80, 4'h4);
    setPort(1, FP_ALU_SUB, 16'h4040, 16'h3F80, 4'h6);
    checkOutput("alt_model_res0", 32'(expRes[0]), 32'h4000);
    checkOutput("alt_model_res1", 32'(expRes[1]), 32'h4000);
    for (int k = 0; k < 4; k++) applyStimulus(2'b11, 0, 1'b1);
    reqValid = 2'b00;

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      int p;
      p = vecs[v].port ? 1 : 0;
      reqOp[p]  = vecs[v].op;
      reqA[p]   = vecs[v].a;
      reqB[p]   = vecs[v].b;
      reqTag[p] = vecs[v].tag;
      expRes[p] = vecs[v].res;
      expErr[p] = vecs[v].err;
      applyStimulus(vecs[v].port ? 2'b10 : 2'b01, 0, 1'b0);
    end

    // Backpressure for 5 cycles with the other requester waiting
    setPort(0, FP_ALU_ADD, 16'h4000, 16'h4000, 4'h8);
    setPort(1, FP_ALU_SUB, 16'h4080, 16'h3F80, 4'h2);
    applyStimulus(2'b11, 5, 1'b1);
    applyStimulus(2'b11, 0, 1'b0);

    // Flush during EXEC: no response, pointer untouched
    setPort(0, FP_ALU_ADD, 16'h3F80, 16'h3F80, 4'h1);
    reqValid = 2'b01;
    #1;
    checkOutput("flush_exec_grant", 32'(reqReady), 32'd1);
    tick();
    modelPtr = 1'b1;
    reqValid = 2'b00;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    checkOutput("flush_busy_low", 32'(busy), 32'd0);
    sawValid = rspValid;
    repeat (LATENCY + 3) begin
      tick();
      sawValid = sawValid | rspValid;
    end
    checkOutput("flush_no_rsp", 32'(sawValid), 32'd0);
    setPort(1, FP_ALU_SUB, 16'h4040, 16'h3F80, 4'hD);
    applyStimulus(2'b11, 0, 1'b0);
    applyStimulus(2'b01, 0, 1'b0);

    // Flush in IDLE blocks acceptance for that cycle
    reqValid = 2'b01;
    flush    = 1'b1;
    #1;
    checkOutput("flush_idle_ready", 32'(reqReady), 32'd0);
    tick();
    checkOutput("flush_idle_busy", 32'(busy), 32'd0);
    flush    = 1'b0;
    reqValid = 2'b00;

    // Flush coinciding with the response handshake
    reqValid = 2'b01;
    tick();
    modelPtr = 1'b1;
    reqValid = 2'b00;
    repeat (LATENCY) tick();
    checkOutput("flush_resp_valid", 32'(rspValid), 32'd1);
    flush    = 1'b1;
    rspReady = 1'b1;
    tick();
    flush    = 1'b0;
    rspReady = 1'b0;
    checkOutput("flush_resp_cleared", 32'({rspValid, busy}), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 2; p++) begin
        fp_alu_op_e op;
        if ($urandom_range(0, 7) == 0) op = FP_ALU_MAX;
        else op = ($urandom_range(0, 1) == 0) ? FP_ALU_ADD : FP_ALU_SUB;
        setPort(p, op, randBf16(), randBf16(), 4'($urandom));
      end
      applyStimulus(2'($urandom_range(1, 3)), int'($urandom_range(0, 2)), 1'b0);
    end

    // Asynchronous reset while in RESP
    setPort(0, FP_ALU_ADD, 16'h3F80, 16'h4000, 4'h5);
    reqValid = 2'b01;
    tick();
    reqValid = 2'b11;
    repeat (LATENCY) tick();
    checkOutput("areset_pre_valid", 32'(rspValid), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("areset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("areset_busy", 32'(busy), 32'd0);
    checkOutput("areset_req_ready", 32'(reqReady), 32'd0);
    checkOutput("areset_result", 32'(rspResult), 32'd0);
    @(negedge clk);
    rstN     = 1'b1;
    modelPtr = 1'b0;
    setPort(1, FP_ALU_SUB, 16'h4000, 16'h3F80, 4'h9);
    applyStimulus(2'b11, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_arbiter.md
Name: fpu_addsub_arbiter

Overview:
Shares the single combinational bfloat16 add/sub datapath (Add_Sub) between two requesters: port 0 is the core FP issue path and port 1 is the accumulate/reduction engine. Requests are granted round-robin and operands are registered. The datapath is run as a multicycle path of LATENCY cycles. The result is held in an output register until the consumer accepts it. One operation is in flight at a time.

Parameters:
LATENCY, 2, number of cycles the registered operands are held before the datapath result is sampled; legal range 1..15.
TAG_W, 4, width of the opaque requester tag returned with the result.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  abort any in-flight operation and drop the pending result
req_valid_i  input  2  per-requester request valid
req_ready_o  output  2  per-requester request ready; at most one bit set
req_op_i  input  2 x fp_alu_op_e  per-requester operation
req_a_i  input  2 x 16  per-requester operand A (bf16)
req_b_i  input  2 x 16  per-requester operand B (bf16)
req_tag_i  input  2 x TAG_W  per-requester tag
rsp_valid_o  output  1  result valid
rsp_ready_i  input  1  result accepted by consumer
rsp_id_o  output  1  index of the requester that owns the result
rsp_result_o  output  16  bf16 result
rsp_tag_o  output  TAG_W  tag echoed from the request
rsp_err_o  output  1  request carried an operation other than FP_ALU_ADD or FP_ALU_SUB
busy_o  output  1  state != IDLE

Behaviour:
- Reset (async, rst_ni low) puts the block in this state:
  - state IDLE; priority pointer favours requester 0;
  - every registered output and operand/result register is 0;
  - req_ready_o = 0; rsp_valid_o = 0.
- Reset asserted mid-operation discards all state immediately.
- States:
  - IDLE: req_ready_o[g] = 1 only for the granted index g, and only when flush_i = 0.
    - Grant rule: if exactly one req_valid_i bit is set, that requester is granted. If both are set, the requester the pointer favours is granted.
    - Handshake (valid & ready) at edge E:
      - latch op/a/b/tag/id into the operand registers;
      - set the pointer to favour the other requester;
      - load the counter with LATENCY-1;
      - go to EXEC.
    - The pointer is unchanged when there is no handshake.
  - EXEC: operand registers are held stable and drive the datapath.
    - Counter decrements each cycle.
    - At the edge where counter = 0:
      - capture the datapath output into rsp_result_o;
      - capture the latched tag/id;
      - set rsp_err_o;
      - go to RESP.
  - RESP: rsp_valid_o = 1; all response outputs are held stable.
    - rsp_valid_o & rsp_ready_i at an edge -> IDLE.
    - Requesters are not accepted in RESP. Back-to-back throughput is 1 operation per LATENCY+2 cycles.
- Latency: handshake at edge E -> rsp_valid_o high in the cycle after edge E+LATENCY. With LATENCY = 2, rsp_valid_o is high 3 cycles after the accept cycle.
- Invalid operation (op is not ADD or SUB):
  - accepted normally and uses the same latency;
  - rsp_result_o = FP_BF16_QNAN (16'h7FC0), rsp_err_o = 1;
  - the datapath output is ignored.
- Datapath input for a valid operation: the latched op is passed to the datapath unchanged. NaN/Inf handling is entirely the datapath's.
- flush_i:
  - In any state, the next edge goes to IDLE, clears rsp_valid_o and discards the result. No response is ever issued for a flushed operation.
  - The pointer is not modified.
  - In IDLE, flush_i forces req_ready_o = 0 so nothing is accepted in that cycle.
- Simultaneous flush_i and rsp handshake in RESP: treated as a completed handshake. State goes to IDLE either way.
- Requesters must hold valid and payload stable until ready; the block does not check this.

Decomposition:
- In ibex_pkg:
  - add the FP_BF16_QNAN constant;
  - add the fpu_arb_state_e enum {ARB_IDLE, ARB_EXEC, ARB_RESP};
  - reuse the existing fp_alu_op_e.
- Sub-module fpu_rr_arb2: 2-way round-robin grant logic with its own pointer flop and an advance strobe.
- The Add_Sub datapath is instantiated inside fpu_addsub_arbiter.
- For timing, the EXEC window is constrained as a LATENCY-cycle multicycle path.

Test Plan:
1. Only requester 0 issues FP_ALU_ADD a=0x3F80, b=0x4000, tag=5, LATENCY=2 -> exactly 3 cycles after the accept cycle: rsp_valid_o=1, result=0x4040, id=0, tag=5, err=0.
2. After reset, both requesters valid in the same cycle:
   - req0 ADD 0x3F80+0x3F80;
   - req1 SUB 0x4040-0x3F80;
   - rsp_ready_i tied high;
   - expected: req0 granted first -> 0x4000 with id 0, then req1 -> 0x4000 with id 1;
   - with both held valid, grants continue to alternate 0,1,0,1.
3. Response backpressure: rsp_ready_i held low for 5 cycles -> rsp_valid_o and all response outputs stay stable, req_ready_o = 0 throughout; the single handshake then returns to IDLE and the next request is accepted on the following edge.
4. Invalid op (any fp_alu_op_e other than ADD or SUB) on req1, tag=3 -> result 0x7FC0, err=1, id=1, tag=3, same latency as case 1.
5. flush_i pulsed for 1 cycle during EXEC -> rsp_valid_o never rises, busy_o falls after the next edge; a following req0 ADD completes normally and is granted per the unchanged pointer.
6. rst_ni driven low asynchronously while in RESP -> rsp_valid_o, busy_o and req_ready_o drop to 0 without waiting for a clock edge; after release the pointer favours requester 0.
